load_unit: RTL and testbench

- Multi-cycle load-word (LW) execution unit. It is the read-side counterpart of the store datapath.
- Reads a base register and adds the sign-extended 16-bit offset to form the effective address.
- Issues a read request to data memory, waits for the acknowledge, then writes the loaded word into the destination register.
- Sits between the register file and the data memory in the execute/memory stages. It is driven by the controller through a start/busy/done handshake.

---
 rtl/load_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: multi-cycle load-word execution unit.
// Reads a base register, adds the sign-extended offset, reads data memory and
// writes the loaded word back to the register file.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands latched on acceptance
// RDBASE | base register on rf_raddr, effective address formed/checked
// REQ    | mem_req held with stable mem_addr until mem_ack or timeout
// WB     | single-cycle register write of the loaded word, done pulse
module load_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           offset,
  input  logic [REG_ADDR_W-1:0] base_reg,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDBASE = 2'd1,
    S_REQ    = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           offset_q, offset_d;
  logic [REG_ADDR_W-1:0] base_q, base_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0]     ea_q, ea_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  tout_q, tout_d;

  logic [ADDR_W-1:0]     ea_calc;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  misaligned;

  // Effective address from the base register and sign-extended immediate.
  always_comb begin
    ea_calc    = ADDR_W'(rf_rdata) + {{(ADDR_W-16){offset_q[15]}}, offset_q};
    misaligned = (state_q == S_RDBASE) && (ea_calc[1:0] != 2'b00);
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  // State register and datapath flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      offset_q <= '0;
      base_q   <= '0;
      dest_q   <= '0;
      ea_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      base_q   <= base_d;
      dest_q   <= dest_d;
      ea_q     <= ea_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    base_d   = base_q;
    dest_d   = dest_q;
    ea_d     = ea_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          offset_d = offset;
          base_d   = base_reg;
          dest_d   = dest_reg;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_RDBASE;
        end
      end
      S_RDBASE: begin
        if (misaligned) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ea_d    = ea_calc;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_WB;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          // Abort: the done/err pulse is raised in the following IDLE cycle.
          cnt_d   = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state; a misaligned address is flagged
  // in the RDBASE cycle itself so done/err appear one cycle after start.
  always_comb begin
    rf_raddr = '0;
    mem_req  = 1'b0;
    mem_addr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    busy     = (state_q != S_IDLE);
    done     = tout_q;
    err      = err_q;
    case (state_q)
      S_RDBASE: begin
        rf_raddr = base_q;
        if (misaligned) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ea_q;
      end
      S_WB: begin
        rf_we    = (dest_q != '0);
        rf_waddr = dest_q;
        rf_wdata = data_q;
        done     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed loads against a cycle-timeline model of the unit.
module tb_load_unit;

  localparam int MEM_TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] offset;
  logic [4:0]  base_reg;
  logic [4:0]  dest_reg;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic        done;
  logic        err;

  load_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .offset    (offset),
    .base_reg  (base_reg),
    .dest_reg  (dest_reg),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file and memory environment.
  logic [31:0] rf_mem [32];
  logic [31:0] mem_data = 32'h0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          req_cnt = 0;

  assign rf_rdata  = rf_mem[rf_raddr];
  assign mem_rdata = mem_data;
  assign mem_ack   = ack_force | (mem_req && (req_cnt == ack_delay));

  always @(posedge clk) req_cnt <= mem_req ? req_cnt + 1 : 0;

  // Write log of register-file writes made by the unit.
  int          wr_cnt = 0;
  logic [4:0]  last_waddr = 5'd0;
  logic [31:0] last_wdata = 32'h0;

  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= rf_waddr;
      last_wdata <= rf_wdata;
    end
  end

  // Model of the current load: what happens k cycles after acceptance.
  logic        m_active = 1'b0;
  int          t0 = 0;
  logic [31:0] m_ea = 32'h0;
  logic        m_mis = 1'b0;
  int          m_delay = 0;
  logic [4:0]  m_dest = 5'd0;
  logic [4:0]  m_base = 5'd0;
  logic        m_prev_err = 1'b0;
  int          wr_cnt0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic final_err();
    return m_mis || (m_delay >= MEM_TO);
  endfunction

  // Per-cycle comparison against the model timeline.
  int   k_c, last_req, end_k;
  logic to_c, e_busy, e_done, e_err, e_req, e_we, e_rd;

  always @(negedge clk) begin
    if (m_active) begin
      k_c    = cyc - t0;
      e_busy = 1'b0; e_done = 1'b0; e_err = m_prev_err;
      e_req  = 1'b0; e_we = 1'b0; e_rd = 1'b0;
      if (k_c >= 1) begin
        if (m_mis) begin
          e_err = 1'b1;
          if (k_c == 1) begin e_busy = 1'b1; e_done = 1'b1; e_rd = 1'b1; end
        end else begin
          to_c     = (m_delay >= MEM_TO);
          last_req = to_c ? 1 + MEM_TO : 2 + m_delay;
          end_k    = to_c ? 2 + MEM_TO : 3 + m_delay;
          e_err    = 1'b0;
          if (k_c == 1) begin
            e_busy = 1'b1; e_rd = 1'b1;
          end else if (k_c <= last_req) begin
            e_busy = 1'b1; e_req = 1'b1;
          end else if (k_c == end_k) begin
            e_done = 1'b1;
            if (to_c) e_err = 1'b1;
            else begin e_busy = 1'b1; e_we = (m_dest != 5'd0); end
          end else begin
            e_err = to_c;
          end
        end
      end
      check("busy",    32'(busy),    32'(e_busy));
      check("done",    32'(done),    32'(e_done));
      check("err",     32'(err),     32'(e_err));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("rf_we",   32'(rf_we),   32'(e_we));
      if (e_req) check("mem_addr", mem_addr, m_ea);
      if (e_we) begin
        check("rf_waddr", 32'(rf_waddr), 32'(m_dest));
        check("rf_wdata", rf_wdata, mem_data);
      end
      if (e_rd) check("rf_raddr", 32'(rf_raddr), 32'(m_base));
    end
  end

  // Start one load; returns one cycle after acceptance with start low.
  task automatic launch(input logic [4:0] b, input logic [31:0] bval, input logic [15:0] off,
                        input logic [4:0] d, input logic [31:0] data, input int delay,
                        input logic [31:0] lit_ea);
    @(posedge clk); #1;
    m_prev_err = m_active ? final_err() : 1'b0;
    rf_mem[b]  = bval;
    base_reg   = b;
    offset     = off;
    dest_reg   = d;
    mem_data   = data;
    ack_delay  = delay;
    m_ea       = bval + {{16{off[15]}}, off};
    m_mis      = (m_ea[1:0] != 2'b00);
    m_delay    = delay;
    m_dest     = d;
    m_base     = b;
    wr_cnt0    = wr_cnt;
    t0         = cyc;
    m_active   = 1'b1;
    check("model_ea", m_ea, lit_ea);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done and check latency plus the resulting write.
  task automatic finish(input int exp_k, input logic exp_wr, input logic [4:0] exp_waddr,
                        input logic [31:0] exp_wdata);
    int k = -1;
    for (int i = 0; i < 40 && k < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) k = cyc - t0;
    end
    check("done_cycle", 32'(k), 32'(exp_k));
    @(negedge clk);
    @(negedge clk);
    check("write_count", 32'(wr_cnt - wr_cnt0), 32'(exp_wr));
    if (exp_wr) begin
      check("wb_addr", 32'(last_waddr), 32'(exp_waddr));
      check("wb_data", last_wdata, exp_wdata);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_done"},     32'(done),     32'h0);
    check({tag, "_err"},      32'(err),      32'h0);
    check({tag, "_mem_req"},  32'(mem_req),  32'h0);
    check({tag, "_mem_addr"}, mem_addr,      32'h0);
    check({tag, "_rf_we"},    32'(rf_we),    32'h0);
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'h0);
    check({tag, "_rf_wdata"}, rf_wdata,      32'h0);
    check({tag, "_rf_raddr"}, 32'(rf_raddr), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    reset    = 1'b0;
    start    = 1'b0;
    offset   = 16'h0;
    base_reg = 5'd0;
    dest_reg = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Basic load.
    launch(5'd3, 32'h0000_1000, 16'h0008, 5'd5, 32'hDEAD_BEEF, 0, 32'h0000_1008);
    finish(3, 1'b1, 5'd5, 32'hDEAD_BEEF);

    // Negative offset wrapping below zero, one wait state.
    launch(5'd7, 32'h0000_0004, 16'hFFF8, 5'd9, 32'h1234_5678, 1, 32'hFFFF_FFFC);
    finish(4, 1'b1, 5'd9, 32'h1234_5678);

    // Misaligned address; a stray mem_ack is present throughout.
    ack_force = 1'b1;
    launch(5'd2, 32'h0000_0100, 16'h0002, 5'd6, 32'h5555_AAAA, 0, 32'h0000_0102);
    finish(1, 1'b0, 5'd0, 32'h0);
    ack_force = 1'b0;

    // Four wait states with a start pulse while busy.
    launch(5'd3, 32'h0000_2000, 16'h0010, 5'd10, 32'hA5A5_0001, 4, 32'h0000_2010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start    = 1'b1;
    base_reg = 5'd1;
    offset   = 16'h0004;
    dest_reg = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    finish(7, 1'b1, 5'd10, 32'hA5A5_0001);

    // No acknowledge: timeout abort.
    launch(5'd4, 32'h0000_3000, 16'hFFFC, 5'd11, 32'h0BAD_0BAD, 255, 32'h0000_2FFC);
    finish(17, 1'b0, 5'd0, 32'h0);

    // Destination r0: done but no write.
    launch(5'd1, 32'h0000_0040, 16'h0000, 5'd0, 32'hFFFF_0000, 0, 32'h0000_0040);
    finish(3, 1'b0, 5'd0, 32'h0);

    // Reset during REQ abandons the load.
    launch(5'd5, 32'h0000_0500, 16'h0000, 5'd7, 32'h1111_2222, 255, 32'h0000_0500);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_active = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    check("midreset_idle", 32'(busy), 32'h0);
    check("midreset_nowrite", 32'(wr_cnt - wr_cnt0), 32'h0);

    // Clean load after reset.
    launch(5'd3, 32'h0000_1000, 16'h0020, 5'd12, 32'hCAFE_F00D, 0, 32'h0000_1020);
    finish(3, 1'b1, 5'd12, 32'hCAFE_F00D);

    m_active = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
